// File: rtl/spi_slave_port_pkg.sv
// Shared definitions for the SPI slave port: the CPU register map, the status
// layout and the shifter control states.
`timescale 1ns/1ps
package spi_slave_port_pkg;

    localparam int unsigned CPU_DW = 16;
    localparam int unsigned ADDR_W = 3;

    // Register addresses, identical to the SPI master map
    localparam logic [ADDR_W-1:0] ADDR_RXDATA   = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_TXDATA   = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_STATUS   = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_CONTROL  = 3'd3;
    localparam logic [ADDR_W-1:0] ADDR_EOPVALUE = 3'd6;

    // Status bits [9:3]; the control register uses the same positions as irq enables
    localparam logic [CPU_DW-1:0] IRQ_MASK = 16'h03F8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2
    } spi_state_e;

    typedef struct packed {
        logic eop;
        logic e;
        logic rrdy;
        logic trdy;
        logic tmt;
        logic toe;
        logic roe;
    } spi_status_t;

    // Place the status flags at their register bit positions
    function automatic logic [CPU_DW-1:0] pack_status(input spi_status_t s);
        return {6'd0, s.eop, s.e, s.rrdy, s.trdy, s.tmt, s.toe, s.roe, 3'd0};
    endfunction

endpackage

// File: rtl/spi_slave_port_sync.sv
// Input synchronizer for the SPI pins plus edge pulses.
// Ports:
//   clk, reset_n          system clock, async active-low reset
//   sclk_i, ss_n_i, mosi_i raw asynchronous pins
//   mosi_s_o              synchronized MOSI, aligned with the SCLK edge pulses
//   sclk_rise_c/fall_c    one-clk SCLK edge pulses, only while SS_n is low
//   ss_fall_c/ss_rise_c   one-clk slave-select edge pulses
`timescale 1ns/1ps
module spi_slave_port_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic sclk_i,
    input  logic ss_n_i,
    input  logic mosi_i,
    output logic mosi_s_o,
    output logic sclk_rise_c,
    output logic sclk_fall_c,
    output logic ss_fall_c,
    output logic ss_rise_c
);

    logic [SYNC_STAGES-1:0] sclk_q;
    logic [SYNC_STAGES-1:0] ss_n_q;
    logic [SYNC_STAGES-1:0] mosi_q;
    logic                   sclk_prev_q;
    logic                   ss_n_prev_q;
    logic                   sclk_s;
    logic                   ss_n_s;

    // Synchronizer chains; SS_n resets to the deselected level
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk_q      <= '0;
            ss_n_q      <= '1;
            mosi_q      <= '0;
            sclk_prev_q <= 1'b0;
            ss_n_prev_q <= 1'b1;
        end else begin
            sclk_q      <= {sclk_q[SYNC_STAGES-2:0], sclk_i};
            ss_n_q      <= {ss_n_q[SYNC_STAGES-2:0], ss_n_i};
            mosi_q      <= {mosi_q[SYNC_STAGES-2:0], mosi_i};
            sclk_prev_q <= sclk_q[SYNC_STAGES-1];
            ss_n_prev_q <= ss_n_q[SYNC_STAGES-1];
        end
    end

    assign sclk_s      = sclk_q[SYNC_STAGES-1];
    assign ss_n_s      = ss_n_q[SYNC_STAGES-1];
    assign mosi_s_o    = mosi_q[SYNC_STAGES-1];
    assign sclk_rise_c = sclk_s & ~sclk_prev_q & ~ss_n_s;
    assign sclk_fall_c = ~sclk_s & sclk_prev_q & ~ss_n_s;
    assign ss_fall_c   = ~ss_n_s & ss_n_prev_q;
    assign ss_rise_c   = ss_n_s & ~ss_n_prev_q;

endmodule

// File: rtl/spi_slave_port.sv
// SPI mode-0 slave (MSB first) with the SPI master's CPU register map.
// Ports:
//   clk, reset_n                 system clock (>= 8x SCLK), async active-low reset
//   SCLK, SS_n, MOSI             SPI pins from the master (asynchronous)
//   MISO, MISO_oe                serial data to the master and its pad enable
//   spi_select, mem_addr,
//   read_n, write_n,
//   data_from_cpu, data_to_cpu   CPU register port (two-cycle accesses)
//   irq                          registered interrupt
//   dataavailable/readyfordata/
//   endofpacket                  RRDY / TRDY / EOP status
`timescale 1ns/1ps
module spi_slave_port
    import spi_slave_port_pkg::*;
#(
    parameter int unsigned DATABITS    = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              SCLK,
    input  logic              SS_n,
    input  logic              MOSI,
    output logic              MISO,
    output logic              MISO_oe,
    input  logic              spi_select,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic              read_n,
    input  logic              write_n,
    input  logic [CPU_DW-1:0] data_from_cpu,
    output logic [CPU_DW-1:0] data_to_cpu,
    output logic              irq,
    output logic              dataavailable,
    output logic              readyfordata,
    output logic              endofpacket
);

    localparam int unsigned CNT_W = $clog2(DATABITS + 1);

    spi_state_e          state_q;
    logic [CNT_W-1:0]    bitcnt_q;
    logic [DATABITS-1:0] tx_shift_q;
    logic [DATABITS-1:0] rx_shift_q;
    logic                miso_oe_q;

    logic [DATABITS-1:0] tx_hold_q;
    logic [DATABITS-1:0] rx_hold_q;
    logic [DATABITS-1:0] eopval_q;
    logic [CPU_DW-1:0]   ctrl_q;
    logic [CPU_DW-1:0]   data_to_cpu_q;
    logic                primed_q;
    logic                rrdy_q;
    logic                roe_q;
    logic                toe_q;
    logic                eop_q;
    logic                irq_q;
    logic                rd_blk_q;
    logic                wr_blk_q;

    logic                mosi_s;
    logic                sclk_rise;
    logic                sclk_fall;
    logic                ss_fall;
    logic                ss_rise;

    spi_slave_port_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk         (clk),
        .reset_n     (reset_n),
        .sclk_i      (SCLK),
        .ss_n_i      (SS_n),
        .mosi_i      (MOSI),
        .mosi_s_o    (mosi_s),
        .sclk_rise_c (sclk_rise),
        .sclk_fall_c (sclk_fall),
        .ss_fall_c   (ss_fall),
        .ss_rise_c   (ss_rise)
    );

    // CPU strobes act on the first cycle only; the following cycle is blocked
    logic rd_stb, wr_stb;
    logic rx_rd, tx_wr, stat_wr, ctrl_wr, eopv_wr;
    logic [DATABITS-1:0] wdata;

    assign rd_stb  = spi_select & ~read_n & ~rd_blk_q;
    assign wr_stb  = spi_select & ~write_n & ~wr_blk_q;
    assign rx_rd   = rd_stb & (mem_addr == ADDR_RXDATA);
    assign tx_wr   = wr_stb & (mem_addr == ADDR_TXDATA);
    assign stat_wr = wr_stb & (mem_addr == ADDR_STATUS);
    assign ctrl_wr = wr_stb & (mem_addr == ADDR_CONTROL);
    assign eopv_wr = wr_stb & (mem_addr == ADDR_EOPVALUE);
    assign wdata   = data_from_cpu[DATABITS-1:0];

    // Frame events shared by the shifter and the register file
    logic                byte_done, reload, load_now;
    logic [DATABITS-1:0] rx_next;
    logic [DATABITS-1:0] load_val;

    assign rx_next   = DATABITS'({rx_shift_q, mosi_s});
    assign byte_done = (state_q == ST_SHIFT) & sclk_rise & (bitcnt_q == CNT_W'(DATABITS - 1));
    assign reload    = (state_q == ST_SHIFT) & sclk_fall & (bitcnt_q == CNT_W'(DATABITS));
    assign load_now  = (state_q == ST_LOAD) | reload;
    assign load_val  = primed_q ? tx_hold_q : '0;

    spi_status_t status;
    always_comb begin
        status      = '0;
        status.eop  = eop_q;
        status.e    = roe_q | toe_q;
        status.rrdy = rrdy_q;
        status.trdy = ~primed_q;
        status.tmt  = (state_q == ST_IDLE) & ~primed_q;
        status.toe  = toe_q;
        status.roe  = roe_q;
    end

    logic [CPU_DW-1:0] rd_mux;
    always_comb begin
        rd_mux = '0;
        case (mem_addr)
            ADDR_RXDATA:   rd_mux = CPU_DW'(rx_hold_q);
            ADDR_STATUS:   rd_mux = pack_status(status);
            ADDR_CONTROL:  rd_mux = ctrl_q;
            ADDR_EOPVALUE: rd_mux = CPU_DW'(eopval_q);
            default:       rd_mux = '0;
        endcase
    end

    // Shifter control: IDLE -> LOAD -> SHIFT, reloading at each byte boundary
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            bitcnt_q   <= '0;
            tx_shift_q <= '0;
            rx_shift_q <= '0;
            miso_oe_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    bitcnt_q  <= '0;
                    miso_oe_q <= 1'b0;
                    if (ss_fall) begin
                        state_q   <= ST_LOAD;
                        miso_oe_q <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    tx_shift_q <= load_val;
                    bitcnt_q   <= '0;
                    state_q    <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (sclk_rise) begin
                        rx_shift_q <= rx_next;
                        bitcnt_q   <= bitcnt_q + CNT_W'(1);
                    end
                    if (reload) begin
                        tx_shift_q <= load_val;
                        bitcnt_q   <= '0;
                    end else if (sclk_fall) begin
                        tx_shift_q <= tx_shift_q << 1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
            // Deselect mid-frame drops the partial byte silently
            if (ss_rise && (state_q != ST_IDLE)) begin
                state_q   <= ST_IDLE;
                bitcnt_q  <= '0;
                miso_oe_q <= 1'b0;
            end
        end
    end

    // CPU register file and flags; later assignments express the same-cycle priorities
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_hold_q     <= '0;
            rx_hold_q     <= '0;
            eopval_q      <= '0;
            ctrl_q        <= '0;
            data_to_cpu_q <= '0;
            primed_q      <= 1'b0;
            rrdy_q        <= 1'b0;
            roe_q         <= 1'b0;
            toe_q         <= 1'b0;
            eop_q         <= 1'b0;
            irq_q         <= 1'b0;
            rd_blk_q      <= 1'b0;
            wr_blk_q      <= 1'b0;
        end else begin
            rd_blk_q      <= rd_stb;
            wr_blk_q      <= wr_stb;
            data_to_cpu_q <= rd_mux;
            irq_q         <= |(pack_status(status) & ctrl_q);

            if (load_now) begin
                primed_q <= 1'b0;
            end
            // A load in the same cycle frees the holding register, so no overrun
            if (tx_wr) begin
                if (!primed_q || load_now) begin
                    tx_hold_q <= wdata;
                    primed_q  <= 1'b1;
                end else begin
                    toe_q <= 1'b1;
                end
                if (wdata == eopval_q) begin
                    eop_q <= 1'b1;
                end
            end

            if (rx_rd) begin
                rrdy_q <= 1'b0;
                if (rx_hold_q == eopval_q) begin
                    eop_q <= 1'b1;
                end
            end

            if (stat_wr) begin
                rrdy_q <= 1'b0;
                roe_q  <= 1'b0;
                toe_q  <= 1'b0;
                eop_q  <= 1'b0;
            end

            if (byte_done) begin
                rx_hold_q <= rx_next;
                rrdy_q    <= 1'b1;
                if (rrdy_q && !stat_wr) begin
                    roe_q <= 1'b1;
                end
            end

            if (ctrl_wr) begin
                ctrl_q <= data_from_cpu & IRQ_MASK;
            end
            if (eopv_wr) begin
                eopval_q <= wdata;
            end
        end
    end

    assign MISO          = tx_shift_q[DATABITS-1];
    assign MISO_oe       = miso_oe_q;
    assign data_to_cpu   = data_to_cpu_q;
    assign irq           = irq_q;
    assign dataavailable = rrdy_q;
    assign readyfordata  = ~primed_q;
    assign endofpacket   = eop_q;

endmodule
